// File: rtl/frame_capture_buffer_pkg.sv
// frame_capture_buffer_pkg: shared sizes, write-FSM encoding and helpers for the frame capture buffer.
package frame_capture_buffer_pkg;
   localparam int DATA_W = 16;
   localparam int FRAME_LEN = 2048;
   localparam int ADDR_W = 11;
   localparam int FRAME_TOTAL = 250;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CAPTURE = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/frame_capture_buffer_bank_ram.sv
// frame_capture_buffer_bank_ram: two-bank simple dual-port frame memory with registered read.
module frame_capture_buffer_bank_ram #(
   parameter int DATA_W = frame_capture_buffer_pkg::DATA_W,
   parameter int FRAME_LEN = frame_capture_buffer_pkg::FRAME_LEN,
   parameter int ADDR_W = frame_capture_buffer_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W:0]   wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W:0]   ra,
   output logic [DATA_W-1:0] rd
);
   logic [DATA_W-1:0] mem [0:2*FRAME_LEN-1];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) rd <= '0;
      else rd <= mem[ra];
   end
endmodule

// File: rtl/frame_capture_buffer.sv
// frame_capture_buffer: ping-pong capture of sample bursts into a two-bank frame memory,
// handed to the consumer through valid/ack, with short-burst and overflow reporting.
module frame_capture_buffer #(
   parameter int DATA_W = frame_capture_buffer_pkg::DATA_W,
   parameter int FRAME_LEN = frame_capture_buffer_pkg::FRAME_LEN,
   parameter int ADDR_W = frame_capture_buffer_pkg::ADDR_W,
   parameter int FRAME_TOTAL = frame_capture_buffer_pkg::FRAME_TOTAL
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] signal_in,
   input  logic              data_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              frame_valid,
   input  logic              frame_ack,
   output logic [7:0]        frame_id,
   output logic              last_frame,
   output logic              short_err,
   output logic              overflow,
   output logic [7:0]        drop_cnt
);
   import frame_capture_buffer_pkg::*;

   logic [1:0]        state;
   logic [ADDR_W-1:0] wr_ptr;
   logic              wr_bank, rd_bank;
   logic [1:0]        full;
   logic [1:0][7:0]   tag;
   logic [7:0]        frame_cnt, cnt_next;
   logic              at_end, we, done, ack;

   always_comb begin
      at_end = wr_ptr == ADDR_W'(FRAME_LEN - 1);
      we = data_ready && (state == S_CAPTURE || (state == S_IDLE && !full[wr_bank]));
      done = data_ready && at_end && state == S_CAPTURE;
      ack = frame_ack && frame_valid;
      cnt_next = (frame_cnt == 8'(FRAME_TOTAL - 1)) ? 8'd0 : frame_cnt + 8'd1;
   end

   assign frame_valid = full[rd_bank];
   assign frame_id = tag[rd_bank];
   assign last_frame = tag[rd_bank] == 8'(FRAME_TOTAL - 1);

   // Ack clears before completion sets, so a completion into the released bank leaves it full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         wr_ptr <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         full <= '0;
         tag <= '0;
         frame_cnt <= '0;
         short_err <= 1'b0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (ack) begin
            full[rd_bank] <= 1'b0;
            rd_bank <= ~rd_bank;
         end
         if (done) begin
            full[wr_bank] <= 1'b1;
            tag[wr_bank] <= frame_cnt;
            frame_cnt <= cnt_next;
            wr_bank <= ~wr_bank;
         end
         case (state)
            S_IDLE: if (data_ready) begin
               wr_ptr <= ADDR_W'(1);
               if (full[wr_bank]) begin
                  overflow <= 1'b1;
                  drop_cnt <= sat_inc(drop_cnt);
                  state <= S_DISCARD;
               end else state <= S_CAPTURE;
            end
            S_CAPTURE, S_DISCARD: if (!data_ready) begin
               if (state == S_CAPTURE) short_err <= 1'b1;
               wr_ptr <= '0;
               state <= S_IDLE;
            end else if (at_end) begin
               if (state == S_DISCARD) frame_cnt <= cnt_next;
               wr_ptr <= '0;
               state <= S_IDLE;
            end else wr_ptr <= wr_ptr + ADDR_W'(1);
            default: state <= S_IDLE;
         endcase
      end
   end

   frame_capture_buffer_bank_ram #(
      .DATA_W(DATA_W),
      .FRAME_LEN(FRAME_LEN),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk(clk),
      .reset(reset),
      .we(we),
      .wa({wr_bank, wr_ptr}),
      .wd(signal_in),
      .ra({rd_bank, rd_addr}),
      .rd(rd_data)
   );
endmodule

// File: tb/tb_frame_capture_buffer.sv
// tb_frame_capture_buffer: directed checks of capture, ping-pong handoff, drops, short bursts and reset.
module tb_frame_capture_buffer;
   localparam int DW = 16;
   localparam int FL = 16;
   localparam int AW = 4;
   localparam int FT = 250;

   logic clk = 1'b0;
   logic reset;
   logic [DW-1:0] signal_in;
   logic data_ready;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic frame_valid;
   logic frame_ack;
   logic [7:0] frame_id;
   logic last_frame;
   logic short_err;
   logic overflow;
   logic [7:0] drop_cnt;
   int n_checks = 0;
   int n_errors = 0;

   frame_capture_buffer #(.DATA_W(DW), .FRAME_LEN(FL), .ADDR_W(AW), .FRAME_TOTAL(FT)) dut (
      .clk(clk),
      .reset(reset),
      .signal_in(signal_in),
      .data_ready(data_ready),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .frame_valid(frame_valid),
      .frame_ack(frame_ack),
      .frame_id(frame_id),
      .last_frame(last_frame),
      .short_err(short_err),
      .overflow(overflow),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int v);
      data_ready = 1'b1;
      signal_in = DW'(v);
      tick();
   endtask

   task automatic burst(input int base, input int n);
      for (int i = 0; i < n; i++) sample(base + i);
      data_ready = 1'b0;
      signal_in = '0;
   endtask

   task automatic read_frame(input string tag, input int base);
      for (int k = 0; k < FL; k++) begin
         rd_addr = AW'(k);
         tick();
         chk(tag, 32'(rd_data), 32'(DW'(base + k)));
      end
   endtask

   task automatic ack();
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      data_ready = 1'b0;
      frame_ack = 1'b0;
      signal_in = '0;
      rd_addr = '0;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rd_data"}, 32'(rd_data), 0);
      chk({tag, "_valid"}, 32'(frame_valid), 0);
      chk({tag, "_id"}, 32'(frame_id), 0);
      chk({tag, "_last"}, 32'(last_frame), 0);
      chk({tag, "_short"}, 32'(short_err), 0);
      chk({tag, "_ovf"}, 32'(overflow), 0);
      chk({tag, "_drops"}, 32'(drop_cnt), 0);
   endtask

   initial begin
      reset = 1'b1;
      data_ready = 1'b0;
      frame_ack = 1'b0;
      signal_in = '0;
      rd_addr = '0;
      tick();
      tick();
      chk_zero("reset");
      reset = 1'b0;
      tick();

      // Single ramp frame: valid only after the final sample.
      for (int i = 0; i < FL - 1; i++) sample(i);
      chk("ramp_valid_early", 32'(frame_valid), 0);
      sample(FL - 1);
      data_ready = 1'b0;
      chk("ramp_valid", 32'(frame_valid), 1);
      chk("ramp_id", 32'(frame_id), 0);
      read_frame("ramp_data", 0);
      ack();
      chk("ramp_acked", 32'(frame_valid), 0);

      // Three spaced, acked frames.
      apply_reset();
      for (int f = 0; f < 3; f++) begin
         burst(100 * (f + 1), FL);
         chk("seq_valid", 32'(frame_valid), 1);
         chk("seq_id", 32'(frame_id), 32'(f));
         read_frame("seq_data", 100 * (f + 1));
         ack();
         repeat (20) tick();
      end
      chk("seq_ovf", 32'(overflow), 0);
      chk("seq_short", 32'(short_err), 0);
      // Completion of frame 4 on the same cycle frame 3 is acked.
      burst(400, FL);
      chk("sim_id3", 32'(frame_id), 3);
      for (int i = 0; i < FL - 1; i++) sample(500 + i);
      frame_ack = 1'b1;
      sample(500 + FL - 1);
      frame_ack = 1'b0;
      data_ready = 1'b0;
      chk("sim_valid", 32'(frame_valid), 1);
      chk("sim_id4", 32'(frame_id), 4);
      read_frame("sim_data", 500);

      // No acks: third frame dropped.
      apply_reset();
      burst(1000, FL);
      tick();
      burst(2000, FL);
      tick();
      chk("drop_id_held", 32'(frame_id), 0);
      chk("drop_ovf_pre", 32'(overflow), 0);
      burst(3000, FL);
      tick();
      chk("drop_ovf", 32'(overflow), 1);
      chk("drop_cnt", 32'(drop_cnt), 1);
      chk("drop_valid", 32'(frame_valid), 1);
      read_frame("drop_data_a", 1000);
      ack();
      chk("drop_id_b", 32'(frame_id), 1);
      read_frame("drop_data_b", 2000);
      ack();
      chk("drop_empty", 32'(frame_valid), 0);
      burst(4000, FL);
      chk("drop_id_next", 32'(frame_id), 3);
      read_frame("drop_data_d", 4000);
      chk("drop_ovf_sticky", 32'(overflow), 1);

      // Short burst then a full one.
      apply_reset();
      burst(50, 10);
      tick();
      chk("short_err", 32'(short_err), 1);
      chk("short_valid", 32'(frame_valid), 0);
      burst(500, FL);
      chk("short_next_valid", 32'(frame_valid), 1);
      chk("short_next_id", 32'(frame_id), 0);
      read_frame("short_next_data", 500);

      // Asynchronous reset in the middle of a burst.
      apply_reset();
      burst(60, 5);
      tick();
      burst(7000, FL);
      rd_addr = AW'(3);
      tick();
      chk("pre_reset_rd", 32'(rd_data), 7003);
      chk("pre_reset_short", 32'(short_err), 1);
      for (int i = 0; i < 8; i++) sample(9000 + i);
      #2 reset = 1'b1;
      #1 chk_zero("async_reset");
      data_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      burst(7100, FL);
      chk("post_reset_valid", 32'(frame_valid), 1);
      chk("post_reset_id", 32'(frame_id), 0);
      read_frame("post_reset_data", 7100);

      // Full record: last_frame only on frame 249, then wrap.
      apply_reset();
      for (int f = 0; f <= FT; f++) begin
         burst(f, FL);
         chk("rec_id", 32'(frame_id), 32'(f % FT));
         chk("rec_last", 32'(last_frame), 32'(f == FT - 1));
         ack();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/frame_capture_buffer.md
Name: frame_capture_buffer

Overview:
- Receiving end of the sample-stream interface that feeds the 1D convolution front end: a data-ready strobe qualifying 16-bit samples, in bursts of FRAME_LEN consecutive cycles.
- Captures each burst into one bank of a two-bank (ping-pong) frame memory.
- Presents completed frames to the downstream convolution engine through a random-access read port with a valid/ack handshake.
- Flags short bursts and frames dropped because no bank was free.

Parameters:
- DATA_W, 16: sample width.
- FRAME_LEN, 2048: samples per frame.
- ADDR_W, 11: log2(FRAME_LEN).
- FRAME_TOTAL, 250: frames per full record; drives last_frame.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- signal_in  in  DATA_W  incoming sample, signed two's complement.
- data_ready  in  1  qualifies signal_in on the current cycle.
- rd_addr  in  ADDR_W  sample index within the presented frame.
- rd_data  out  DATA_W  sample at rd_addr; 1-cycle latency.
- frame_valid  out  1  a complete frame is presented on the read side.
- frame_ack  in  1  one-cycle pulse: consumer is done with the presented frame.
- frame_id  out  8  sequence number of the presented frame (mod 256).
- last_frame  out  1  presented frame is number FRAME_TOTAL-1 of the record.
- short_err  out  1  sticky: a burst ended before FRAME_LEN samples.
- overflow  out  1  sticky: a frame was dropped because both banks were full.
- drop_cnt  out  8  saturating count of dropped frames.

Behaviour:
- Reset (asynchronous, active-high) clears all registers and outputs to 0: rd_data, frame_valid, frame_id, last_frame, short_err, overflow, drop_cnt, wr_ptr, both bank-full flags, wr_bank, rd_bank, frame counter. Memory contents are not cleared. Reset mid-capture discards the partial frame.
- Write FSM states:
  - IDLE: waiting for data_ready.
  - CAPTURE: writing a frame into wr_bank.
  - DISCARD: absorbing a burst that has no free bank.
- IDLE, data_ready=1:
  - If wr_bank is free, write signal_in at address 0, wr_ptr<=1, go to CAPTURE.
  - Otherwise set overflow, increment drop_cnt (saturate at 255), go to DISCARD.
- CAPTURE, data_ready=1: write at wr_ptr, wr_ptr+1.
  - On the write at wr_ptr=FRAME_LEN-1: set full[wr_bank], tag the bank with the frame counter, increment the frame counter, toggle wr_bank, wr_ptr<=0, go to IDLE.
  - A burst longer than FRAME_LEN therefore starts the next frame on the following cycle, via IDLE rules.
- CAPTURE, data_ready=0 with wr_ptr≠0: set short_err, wr_ptr<=0, bank stays free, go to IDLE. The frame counter is not advanced.
- DISCARD: count the burst's samples with wr_ptr, no writes.
  - Return to IDLE on data_ready=0, or after FRAME_LEN samples.
  - The frame counter still advances on a completed dropped frame, so frame_id gaps expose drops.
- Read side:
  - frame_valid = full[rd_bank].
  - frame_id and last_frame come from the tag of rd_bank; last_frame = (tag == FRAME_TOTAL-1).
  - rd_data is registered: rd_data(t+1) = mem[rd_bank][rd_addr(t)]. It is valid regardless of frame_valid, but meaningful only while frame_valid=1.
- frame_ack with frame_valid=1: clear full[rd_bank], toggle rd_bank, next cycle. frame_ack with frame_valid=0 is ignored.
- Simultaneous frame completion and frame_ack, same or different banks: both take effect. If the write completes into the bank being released, the full flag ends set (completion wins).
- Bank order is strict ping-pong. Frames are delivered in capture order; rd_bank never overtakes wr_bank.
- Frame counter wraps modulo FRAME_TOTAL. frame_id equals the counter (mod 256).
- Write and read ports are independent. A read of the bank being written is impossible, because frame_valid requires full.

Decomposition:
- Shared package: DATA_W, FRAME_LEN, ADDR_W, FRAME_TOTAL; write-FSM state encoding (IDLE, CAPTURE, DISCARD).
- Sub-module frame_bank_ram:
  - simple dual-port RAM, depth 2*FRAME_LEN, width DATA_W;
  - write address {wr_bank, wr_ptr}, read address {rd_bank, rd_addr};
  - registered read output, inferable as block RAM.
- Top level holds the FSM, full flags, tags, error logic.

Test Plan:
- One 2048-cycle burst of ramp 0..2047 -> frame_valid rises 1 cycle after the last write; rd_addr=k returns k next cycle; frame_id=0.
- Three bursts 2048 samples each, spaced 16000 cycles apart, with ack after each full read -> frame_id 0,1,2; banks alternate; overflow=0, short_err=0.
- Three bursts with no ack -> first two frames held (frame_valid=1, frame_id=0). Third burst dropped: overflow=1, drop_cnt=1. After two acks the next frame carries frame_id=3.
- Burst of 1000 samples then data_ready low -> short_err=1, frame_valid stays 0. A following full burst is captured with frame_id=0.
- Assert reset at sample 500 of a burst, release, then send a full burst -> all outputs 0 during reset; the new frame is captured from address 0 with frame_id=0.
- 250 consecutive acked frames -> last_frame=1 only on frame_id=249 (frame_id mod 256); the 251st frame has frame_id=0.
